// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: FSM encoding, register bit
// positions and the fixed source numbering of the attached devices.
package irq_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SRC_TIMER = 3'd0,
        SRC_KEY   = 3'd1,
        SRC_SW    = 3'd2
    } src_e;

    localparam int ID_W           = 3;
    localparam int CTRL_GIE_BIT   = 0;
    localparam int CTRL_EOI_BIT   = 1;
    localparam int CTRL_STATE_LSB = 2;
    localparam int CTRL_STATE_MSB = 3;
    localparam int ID_PEND_BIT    = 30;
    localparam int ID_SERV_BIT    = 31;

endpackage

// File: rtl/irq_arbiter_if.sv
// Memory-mapped bus seen by the interrupt arbiter; the CPU/bus fabric is the
// master, the arbiter's register file is the slave.
interface irq_arbiter_if #(
    parameter int BITS = 32
);
    logic            we;
    logic            re;
    logic [BITS-1:0] memAddr;
    logic [BITS-1:0] dataBusIn;
    logic [BITS-1:0] dataBusOut;

    modport master (output we, re, memAddr, dataBusIn, input dataBusOut);
    modport slave  (input we, re, memAddr, dataBusIn, output dataBusOut);
endinterface

// File: rtl/irq_priority_select.sv
// Combinational winner search: first eligible source found when scanning
// upward from start_i with wrap-around. Fixed priority simply uses start_i=0.
module irq_priority_select #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] eligible_i,
    input  logic [2:0]         start_i,
    output logic [2:0]         winner_o,
    output logic               found_o
);

    int                 idx;
    logic [NUM_SRC-1:0] elig_sh;

    // Scan from the farthest position back to start so the nearest hit wins.
    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        idx      = 0;
        elig_sh  = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx     = (int'(start_i) + k) % NUM_SRC;
            elig_sh = eligible_i >> idx;
            if (elig_sh[0]) begin
                winner_o = 3'(idx);
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: masks/enables device lines, raises one CPU request and
// walks it through request/ack/EOI. Define IRQ_ROUND_ROBIN_EN for rotating
// priority; otherwise the lowest eligible index always wins.
//   state   | meaning
//   IDLE    | no source in flight, arbitrate on eligible lines
//   PEND    | cpu_irq high, waiting for cpu_ack
//   SERVICE | CPU handling cur_id, waiting for EOI write
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int              BITS      = 32,
    parameter int              NUM_SRC   = 4,
    parameter logic [BITS-1:0] ID_BASE   = 32'hF000_0100,
    parameter logic [BITS-1:0] MASK_BASE = 32'hF000_0104,
    parameter logic [BITS-1:0] CTRL_BASE = 32'hF000_0108
) (
    input  logic               clk,
    input  logic               reset,
    irq_arbiter_if.slave       bus,
    input  logic [NUM_SRC-1:0] irq_req,
    output logic               cpu_irq,
    input  logic               cpu_ack,
    output logic [2:0]         irq_id
);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               gie_q, gie_d;
    logic [2:0]         cur_id_q, cur_id_d;
    logic [NUM_SRC-1:0] eligible;
    logic [2:0]         start_idx;
    logic [2:0]         winner;
    logic               found;
    logic               hit_id, hit_mask, hit_ctrl;
    logic               wr_mask, wr_ctrl, rd_en;
    logic [BITS-1:0]    rdata;
    logic               unused_data;

    assign hit_id   = (bus.memAddr == ID_BASE);
    assign hit_mask = (bus.memAddr == MASK_BASE);
    assign hit_ctrl = (bus.memAddr == CTRL_BASE);
    assign wr_mask  = bus.we && hit_mask;
    assign wr_ctrl  = bus.we && hit_ctrl;
    assign rd_en    = bus.re && !bus.we;

    assign unused_data = ^bus.dataBusIn[BITS-1:NUM_SRC];

    // Registered mask/GIE only: a write in this cycle affects the next arbitration.
    assign eligible = irq_req & mask_q & {NUM_SRC{gie_q}};

`ifdef IRQ_ROUND_ROBIN_EN
    logic [2:0] rr_ptr_q, rr_ptr_d;

    assign start_idx = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == ST_IDLE && found) begin
            rr_ptr_d = 3'((int'(winner) + 1) % NUM_SRC);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign start_idx = '0;
`endif

    irq_priority_select #(
        .NUM_SRC (NUM_SRC)
    ) u_select (
        .eligible_i (eligible),
        .start_i    (start_idx),
        .winner_o   (winner),
        .found_o    (found)
    );

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        mask_d   = wr_mask ? bus.dataBusIn[NUM_SRC-1:0] : mask_q;
        gie_d    = wr_ctrl ? bus.dataBusIn[CTRL_GIE_BIT] : gie_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d  = ST_PEND;
                    cur_id_d = winner;
                end
            end
            ST_PEND: begin
                if (cpu_ack) begin
                    state_d = ST_SERVICE;
                end else if (wr_ctrl && !bus.dataBusIn[CTRL_GIE_BIT]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (wr_ctrl && bus.dataBusIn[CTRL_EOI_BIT]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            gie_q    <= 1'b0;
            cur_id_q <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            gie_q    <= gie_d;
            cur_id_q <= cur_id_d;
        end
    end

    assign cpu_irq = (state_q == ST_PEND);
    assign irq_id  = cur_id_q;

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            if (hit_id) begin
                rdata[ID_W-1:0]    = cur_id_q;
                rdata[ID_PEND_BIT] = (state_q == ST_PEND);
                rdata[ID_SERV_BIT] = (state_q == ST_SERVICE);
            end else if (hit_mask) begin
                rdata[NUM_SRC-1:0] = mask_q;
            end else if (hit_ctrl) begin
                rdata[CTRL_GIE_BIT]                  = gie_q;
                rdata[CTRL_STATE_MSB:CTRL_STATE_LSB] = state_q;
            end
        end
    end

    assign bus.dataBusOut = rdata;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios with literal expectations, then
// random bus/ack/request traffic compared every cycle to a behavioural model.
module tb_irq_arbiter;
    import irq_arbiter_pkg::*;

    localparam int          BITS    = 32;
    localparam int          NUM_SRC = 4;
    localparam logic [31:0] ID_A    = 32'hF000_0100;
    localparam logic [31:0] MASK_A  = 32'hF000_0104;
    localparam logic [31:0] CTRL_A  = 32'hF000_0108;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_req;
    logic       cpu_ack;
    logic       cpu_irq;
    logic [2:0] irq_id;

    irq_arbiter_if #(.BITS(BITS)) bus ();

    irq_arbiter #(
        .BITS    (BITS),
        .NUM_SRC (NUM_SRC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .irq_req (irq_req),
        .cpu_irq (cpu_irq),
        .cpu_ack (cpu_ack),
        .irq_id  (irq_id)
    );

    always #5 clk = ~clk;

    int  n_vec   = 0;
    int  n_err   = 0;
    bit  check_en = 1'b0;

    // Model state: 0 idle, 1 waiting for ack, 2 in service.
    int         m_state = 0;
    logic [3:0] m_mask  = '0;
    logic       m_gie   = 1'b0;
    int         m_cur   = 0;
    int         m_rr    = 0;

    int         t_next, t_start, t_s;
    logic [3:0] t_elig;
    bit         t_found, t_wr_ctrl;
    logic [31:0] e_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_state = 0; m_mask = '0; m_gie = 1'b0; m_cur = 0; m_rr = 0;
        end else begin
            t_next    = m_state;
            t_elig    = irq_req & m_mask & {4{m_gie}};
            t_wr_ctrl = bus.we && (bus.memAddr == CTRL_A);
`ifdef IRQ_ROUND_ROBIN_EN
            t_start = m_rr;
`else
            t_start = 0;
`endif
            if (m_state == 0) begin
                t_found = 1'b0;
                for (int k = 0; k < NUM_SRC; k++) begin
                    t_s = (t_start + k) % NUM_SRC;
                    if (!t_found && t_elig[t_s]) begin
                        t_found = 1'b1;
                        m_cur   = t_s;
                        m_rr    = (t_s + 1) % NUM_SRC;
                        t_next  = 1;
                    end
                end
            end else if (m_state == 1) begin
                if (cpu_ack) t_next = 2;
                else if (t_wr_ctrl && !bus.dataBusIn[0]) t_next = 0;
            end else begin
                if (t_wr_ctrl && bus.dataBusIn[1]) t_next = 0;
            end
            if (bus.we && bus.memAddr == MASK_A) m_mask = bus.dataBusIn[3:0];
            if (t_wr_ctrl) m_gie = bus.dataBusIn[0];
            m_state = t_next;
        end
    end

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            e_data = '0;
            if (bus.re && !bus.we) begin
                if (bus.memAddr == ID_A)
                    e_data = {m_state == 2, m_state == 1, 27'd0, 3'(m_cur)};
                else if (bus.memAddr == MASK_A)
                    e_data = {28'd0, m_mask};
                else if (bus.memAddr == CTRL_A)
                    e_data = {28'd0, 2'(m_state), 1'b0, m_gie};
            end
            check("cmp_cpu_irq", {31'd0, cpu_irq}, {31'd0, m_state == 1});
            check("cmp_irq_id", {29'd0, irq_id}, 32'(m_cur));
            check("cmp_dataBusOut", bus.dataBusOut, e_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.we = 1'b1; bus.re = 1'b0; bus.memAddr = addr; bus.dataBusIn = data;
        tick();
        bus.we = 1'b0; bus.memAddr = '0; bus.dataBusIn = '0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.re = 1'b1; bus.memAddr = addr;
        #1;
        check(name, bus.dataBusOut, exp);
        tick();
        bus.re = 1'b0; bus.memAddr = '0;
    endtask

    task automatic ack_pulse();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    logic [31:0] r_addr, r_data;

    initial begin
        reset = 1'b1; irq_req = '0; cpu_ack = 1'b0;
        bus.we = 1'b0; bus.re = 1'b0; bus.memAddr = '0; bus.dataBusIn = '0;
        tick();
        check_en = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_cpu_irq", {31'd0, cpu_irq}, 32'd0);
        check("rst_irq_id", {29'd0, irq_id}, 32'd0);
        rd_check("rst_ctrl", CTRL_A, 32'd0);

        // 1: single request from the switch source
        wr(MASK_A, 32'hF);
        wr(CTRL_A, 32'h1);
        irq_req = 4'b1 << SRC_SW;
        check("t1_pre_irq", {31'd0, cpu_irq}, 32'd0);
        tick();
        check("t1_irq", {31'd0, cpu_irq}, 32'd1);
        rd_check("t1_id_pend", ID_A, 32'h4000_0002);

        // 2: ack, then EOI with request held
        ack_pulse();
        check("t2_irq_low", {31'd0, cpu_irq}, 32'd0);
        rd_check("t2_id_serv", ID_A, 32'h8000_0002);
        wr(CTRL_A, 32'h3);
        check("t2_idle_gap", {31'd0, cpu_irq}, 32'd0);
        rd_check("t2_ctrl_idle", CTRL_A, 32'h1);
        check("t2_rearb", {31'd0, cpu_irq}, 32'd1);
        irq_req = '0;
        ack_pulse();
        wr(CTRL_A, 32'h3);

        // 3: two contenders
        reset = 1'b1; tick(); reset = 1'b0;
        wr(MASK_A, 32'hF);
        wr(CTRL_A, 32'h1);
        irq_req = 4'b1010;
        tick();
        check("t3_first", {29'd0, irq_id}, 32'd1);
        ack_pulse();
        wr(CTRL_A, 32'h3);
        check("t3_gap", {31'd0, cpu_irq}, 32'd0);
        tick();
        check("t3_second_irq", {31'd0, cpu_irq}, 32'd1);
`ifdef IRQ_ROUND_ROBIN_EN
        check("t3_second_id", {29'd0, irq_id}, 32'd3);
`else
        check("t3_second_id", {29'd0, irq_id}, 32'd1);
`endif
        irq_req = '0;
        ack_pulse();
        wr(CTRL_A, 32'h3);

        // 4: masked source, unmask, then withdraw GIE while pending
        wr(MASK_A, 32'h7);
        irq_req = 4'b1000;
        tick(); tick(); tick();
        check("t4_masked", {31'd0, cpu_irq}, 32'd0);
        wr(MASK_A, 32'hF);
        tick();
        check("t4_unmasked", {31'd0, cpu_irq}, 32'd1);
        check("t4_id", {29'd0, irq_id}, 32'd3);
        wr(CTRL_A, 32'h0);
        check("t4_gie_off", {31'd0, cpu_irq}, 32'd0);
        rd_check("t4_ctrl", CTRL_A, 32'h0);
        check("t4_id_hold", {29'd0, irq_id}, 32'd3);

        // 5: EOI in idle ignored; reset from service
        wr(CTRL_A, 32'h2);
        rd_check("t5_eoi_idle", CTRL_A, 32'h0);
        wr(CTRL_A, 32'h1);
        tick();
        ack_pulse();
        rd_check("t5_ctrl_serv", CTRL_A, 32'h9);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t5_rst_irq", {31'd0, cpu_irq}, 32'd0);
        rd_check("t5_rst_ctrl", CTRL_A, 32'h0);
        rd_check("t5_rst_mask", MASK_A, 32'h0);
        rd_check("t5_rst_id", ID_A, 32'h0);

        // 6: decode corner cases
        rd_check("t6_unmapped", 32'hF000_010C, 32'h0);
        bus.we = 1'b1; bus.re = 1'b1; bus.memAddr = MASK_A; bus.dataBusIn = '0;
        #1;
        check("t6_read_we", bus.dataBusOut, 32'h0);
        tick();
        bus.we = 1'b0; bus.re = 1'b0; bus.memAddr = '0;
        wr(ID_A, 32'hFFFF_FFFF);
        rd_check("t6_id_ro", ID_A, 32'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) irq_req = 4'($urandom);
            cpu_ack = ($urandom_range(0, 3) == 0);
            bus.we  = ($urandom_range(0, 4) == 0);
            bus.re  = ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 3))
                0:       r_addr = ID_A;
                1:       r_addr = MASK_A;
                2:       r_addr = CTRL_A;
                default: r_addr = 32'hF000_0100 + 32'(4 * $urandom_range(3, 8));
            endcase
            r_data = $urandom;
            if (r_addr == CTRL_A && $urandom_range(0, 4) != 0) r_data[0] = 1'b1;
            bus.memAddr   = r_addr;
            bus.dataBusIn = r_data;
            tick();
        end
        reset = 1'b0; cpu_ack = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
        tick();
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
Memory-mapped interrupt controller sitting between the bus-attached devices (timer, keys, switches) and the pipelined CPU core.
- Collects each device's level-sensitive interrupt-ready line and applies a per-source mask and a global enable.
- Selects one winner and drives a single interrupt request to the CPU.
- Sequences each interrupt through request, acknowledge and end-of-interrupt (EOI) so only one source is in service at a time.

Parameters:
BITS, 32, data/address bus width
NUM_SRC, 4, number of interrupt sources (1..8)
ID_BASE, 32'hF0000100, address of read-only ID/status register
MASK_BASE, 32'hF0000104, address of mask register
CTRL_BASE, 32'hF0000108, address of control register (GIE, EOI, state)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
we  input  1  bus write enable
re  input  1  bus read enable
memAddr  input  BITS  bus address
dataBusIn  input  BITS  write data
dataBusOut  output  BITS  read data; zero when not addressed
irq_req  input  NUM_SRC  level interrupt lines; bit i = source i
cpu_irq  output  1  interrupt request to CPU, registered
cpu_ack  input  1  one-cycle CPU acknowledge of cpu_irq
irq_id  output  3  ID of source currently pending or in service

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk. All state updates on posedge clk.
- Reset values: state=IDLE, mask=0, GIE=0, cur_id=0, cpu_irq=0, irq_id=0, rr_ptr=0. dataBusOut is combinational.
- Eligibility: eligible = irq_req & mask & {NUM_SRC{GIE}}, using the registered mask/GIE values before any same-cycle write.
- State machine:
  - IDLE: if eligible != 0 → PEND; cur_id <= winner.
  - PEND: cpu_irq=1. cpu_ack=1 → SERVICE. GIE cleared by bus write → IDLE (cpu_irq low the next cycle).
  - SERVICE: cpu_irq=0. Write to CTRL_BASE with dataBusIn[1]=1 (EOI) → IDLE.
- cpu_irq is exactly (state==PEND). Latency: eligible seen at edge k → cpu_irq high after edge k.
- irq_id = cur_id. cur_id holds its value until the next arbitration win.
- Source deasserts while in PEND/SERVICE: the sequence completes anyway; the CPU handles it as spurious.
- EOI writes in IDLE or PEND are ignored. cpu_ack outside PEND is ignored.
- EOI and a still-asserted request in the same cycle: return to IDLE, re-arbitrate on the next edge. Minimum gap of 1 IDLE cycle between services.
- Registers:
  - ID read: bits[2:0]=cur_id, bit 30=(state==PEND), bit 31=(state==SERVICE), other bits 0.
  - MASK: read/write bits[NUM_SRC-1:0], upper bits read 0.
  - CTRL: bit0 GIE read/write; bit1 EOI write-only, reads 0; bits[3:2] read-only state encoding (IDLE=0, PEND=1, SERVICE=2).
- Bus:
  - Writes occur when we=1 and the address matches.
  - Reads return data when re=1, we=0 and the address matches; otherwise dataBusOut=0.
  - Writes to ID_BASE are ignored.
- Reset mid-operation (any state): immediate return to reset values, cpu_irq low the next cycle, pending service discarded.

Optional Feature:
IRQ_ROUND_ROBIN_EN
- Defined: rotating priority. The search starts at rr_ptr; rr_ptr <= (winner+1) mod NUM_SRC on each IDLE→PEND transition.
- Undefined: fixed priority, lowest index wins, no rr_ptr register.

Decomposition:
- Shared include irq_defs.vh holds:
  - state encodings IDLE/PEND/SERVICE;
  - CTRL bit positions (GIE=0, EOI=1, STATE=3:2);
  - ID status bit positions (30, 31);
  - source index constants (TIMER=0, KEY=1, SW=2).
- One combinational sub-module, irq_priority_select: inputs eligible and start index, outputs winner and a found flag. Fixed mode ties start to 0.

Test Plan:
1. Reset; MASK=4'hF; CTRL=1; irq_req=4'b0100 → cpu_irq=1 one edge later; ID read=32'h4000_0002.
2. From (1): cpu_ack pulse → cpu_irq=0, ID read=32'h8000_0002. Write CTRL=32'h3 (EOI+GIE) with req held → IDLE one cycle, then cpu_irq=1 again.
3. irq_req=4'b1010, fixed priority → irq_id=1. With IRQ_ROUND_ROBIN_EN after serving 1, req still 4'b1010 → next irq_id=3.
4. MASK=4'b0111, irq_req=4'b1000 → cpu_irq stays 0. Unmask in PEND, then write CTRL=0 → state IDLE, cpu_irq=0 next cycle.
5. EOI write in IDLE → no state change. Reset asserted in SERVICE → CTRL/MASK/ID read 0, cpu_irq=0.
6. Read of an unmapped address, or with we=1 → dataBusOut=0. Write to ID_BASE → ID unchanged.
